// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Merges NUM_CH read requesters onto a single AXI3 AR/R channel pair with
//   one transaction outstanding. The winner index goes out on ARID and the
//   returning beats are steered back to that requester.
//
//   Build option: AXI_RD_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest channel index wins (no rr pointer)
//     undefined -> round-robin starting at the channel after the last owner
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ch_arvalid/araddr/arlen/arsize per-channel read request (packed by channel)
//   ch_arready                    one-hot grant pulse
//   ch_rvalid                     one-hot beat valid to the owner
//   ch_rdata, ch_rlast            broadcast read data / last flag
//   m_ar*                         AXI AR channel master side
//   m_r*, m_rready                AXI R channel master side
//   err_sticky                    protocol error flag, cleared only by reset

module axi_rd_arbiter #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_arvalid,
    input  logic [NUM_CH*ADDR_W-1:0] ch_araddr,
    input  logic [NUM_CH*4-1:0]      ch_arlen,
    input  logic [NUM_CH*3-1:0]      ch_arsize,
    output logic [NUM_CH-1:0]        ch_arready,
    output logic [NUM_CH-1:0]        ch_rvalid,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     ch_rlast,
    output logic [ID_W-1:0]          m_arid,
    output logic [ADDR_W-1:0]        m_araddr,
    output logic [3:0]               m_arlen,
    output logic [2:0]               m_arsize,
    output logic [1:0]               m_arburst,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [ID_W-1:0]          m_rid,
    input  logic [DATA_W-1:0]        m_rdata,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rlast,
    input  logic                     m_rvalid,
    output logic                     m_rready,
    output logic                     err_sticky
);

    localparam int PW = $clog2(NUM_CH);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e            r_state, w_state_nxt;
    logic [PW-1:0]     r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [2:0]        r_size;
    logic [3:0]        r_beat_cnt;
    logic              r_err;

    logic [PW-1:0]     w_start;
    logic [PW-1:0]     w_win;
    logic [PW:0]       w_cand;
    logic              w_found;
    logic              w_beat;
    logic              w_last;
    logic              w_err_now;

    assign w_beat = (r_state == StData) && m_rvalid;
    assign w_last = w_beat && m_rlast;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [PW-1:0] r_rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_last) begin
            r_rr_ptr <= (r_gnt == PW'(NUM_CH - 1)) ? '0 : r_gnt + 1'b1;
        end
    end

    assign w_start = r_rr_ptr;
`endif

    // Circular search from w_start; the first requesting channel wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = {1'b0, w_start} + (PW+1)'(i);
            if (w_cand >= (PW+1)'(NUM_CH)) begin
                w_cand = w_cand - (PW+1)'(NUM_CH);
            end
            if (!w_found && ch_arvalid[w_cand[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[PW-1:0];
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ch_arready  = '0;
        ch_rvalid   = '0;
        ch_rdata    = '0;
        ch_rlast    = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Suppress the grant while reset is held so no requester sees
                // an accept that the state register cannot capture.
                if (w_found && !rst) begin
                    ch_arready[w_win] = 1'b1;
                    w_state_nxt       = StAddr;
                end
            end
            StAddr: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    w_state_nxt = StData;
                end
            end
            StData: begin
                m_rready         = 1'b1;
                ch_rvalid[r_gnt] = m_rvalid;
                ch_rdata         = m_rdata;
                ch_rlast         = m_rlast;
                if (w_last) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // AR fields are only driven while the request is being presented.
    assign m_arid     = (r_state == StAddr) ? ID_W'(r_gnt) : '0;
    assign m_araddr   = (r_state == StAddr) ? r_addr       : '0;
    assign m_arlen    = (r_state == StAddr) ? r_len        : '0;
    assign m_arsize   = (r_state == StAddr) ? r_size       : '0;
    assign m_arburst  = (r_state == StAddr) ? 2'b01        : 2'b00;
    assign err_sticky = r_err;

    assign w_err_now = w_beat && ((m_rlast && (r_beat_cnt != 4'd0)) ||
                                  (!m_rlast && (r_beat_cnt == 4'd0)) ||
                                  (m_rid != ID_W'(r_gnt)) ||
                                  (m_rresp != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_gnt      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == StIdle) && w_found) begin
                r_gnt      <= w_win;
                r_addr     <= ch_araddr[int'(w_win)*ADDR_W +: ADDR_W];
                r_len      <= ch_arlen[int'(w_win)*4 +: 4];
                r_size     <= ch_arsize[int'(w_win)*3 +: 3];
                r_beat_cnt <= ch_arlen[int'(w_win)*4 +: 4];
            end else if (w_beat && (r_beat_cnt != 4'd0)) begin
                // Saturate so an overrunning burst keeps flagging errors.
                r_beat_cnt <= r_beat_cnt - 4'd1;
            end
            if (w_err_now) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Testbench for axi_rd_arbiter: transaction-level model plus directed tests.

module tb_axi_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int OW = N + N + DW + 1 + IW + AW + 4 + 3 + 2 + 1 + 1 + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      ch_arvalid = '0;
    logic [N*AW-1:0]   ch_araddr = '0;
    logic [N*4-1:0]    ch_arlen = '0;
    logic [N*3-1:0]    ch_arsize = '0;
    logic [N-1:0]      ch_arready;
    logic [N-1:0]      ch_rvalid;
    logic [DW-1:0]     ch_rdata;
    logic              ch_rlast;
    logic [IW-1:0]     m_arid;
    logic [AW-1:0]     m_araddr;
    logic [3:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready = 1'b0;
    logic [IW-1:0]     m_rid = '0;
    logic [DW-1:0]     m_rdata = '0;
    logic [1:0]        m_rresp = '0;
    logic              m_rlast = 1'b0;
    logic              m_rvalid = 1'b0;
    logic              m_rready;
    logic              err_sticky;

    axi_rd_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .ch_arvalid(ch_arvalid), .ch_araddr(ch_araddr), .ch_arlen(ch_arlen),
        .ch_arsize(ch_arsize), .ch_arready(ch_arready), .ch_rvalid(ch_rvalid),
        .ch_rdata(ch_rdata), .ch_rlast(ch_rlast),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] out_vec = {ch_arready, ch_rvalid, ch_rdata, ch_rlast, m_arid, m_araddr,
                             m_arlen, m_arsize, m_arburst, m_arvalid, m_rready, err_sticky};

    // ---------------- transaction-level model ----------------
    // phase: 0 waiting for a request, 1 address offered, 2 beats returning
    int          md_phase = 0;
    int          md_ptr   = 0;
    int          md_owner = 0;
    int          md_left  = 0;
    logic        md_err   = 1'b0;
    logic [AW-1:0] md_addr = '0;
    logic [3:0]  md_len  = '0;
    logic [2:0]  md_size = '0;

    function automatic int pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int model_start();
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        return 0;
`else
        return md_ptr;
`endif
    endfunction

    always @(posedge clk) begin : model
        int w;
        if (rst) begin
            md_phase <= 0; md_ptr <= 0; md_owner <= 0; md_left <= 0;
            md_err <= 1'b0; md_addr <= '0; md_len <= '0; md_size <= '0;
        end else begin
            case (md_phase)
                0: begin
                    w = pick(ch_arvalid, model_start());
                    if (w >= 0) begin
                        md_owner <= w;
                        md_addr  <= ch_araddr[w*AW +: AW];
                        md_len   <= ch_arlen[w*4 +: 4];
                        md_size  <= ch_arsize[w*3 +: 3];
                        md_left  <= int'(ch_arlen[w*4 +: 4]) + 1;
                        md_phase <= 1;
                    end
                end
                1: if (m_arready) md_phase <= 2;
                default: begin
                    if (m_rvalid) begin
                        if ((m_rlast && md_left > 1) || (!m_rlast && md_left <= 1) ||
                            (m_rid != IW'(md_owner)) || (m_rresp != 2'b00)) md_err <= 1'b1;
                        if (md_left > 0) md_left <= md_left - 1;
                        if (m_rlast) begin
                            md_ptr   <= (md_owner + 1) % N;
                            md_phase <= 0;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- monitors ----------------
    int hs_cnt = 0;
    int rv_cnt = 0;
    int rl_cnt = 0;
    int glog[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (m_arvalid && m_arready) hs_cnt <= hs_cnt + 1;
            if (|ch_rvalid) rv_cnt <= rv_cnt + 1;
            if (ch_rlast && |ch_rvalid) rl_cnt <= rl_cnt + 1;
            for (int k = 0; k < N; k++) if (ch_arready[k]) glog.push_back(k);
        end
    end

    // ---------------- checks ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        m_rid = '0; m_rresp = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic req(input int ch, input logic [AW-1:0] addr, input logic [3:0] len,
                       output logic [N-1:0] seen);
        logic got;
        got = 1'b0;
        seen = '0;
        ch_araddr[ch*AW +: AW] = addr;
        ch_arlen[ch*4 +: 4]    = len;
        ch_arsize[ch*3 +: 3]   = 3'd2;
        ch_arvalid[ch]         = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (ch_arready[ch]) begin
                got  = 1'b1;
                seen = ch_arready;
            end
            tick();
        end
        ch_arvalid[ch] = 1'b0;
        if (!got) chk("grant_timeout", 64'(seen), 64'(1 << ch));
    endtask

    task automatic ar_accept(input int wait_cyc);
        logic [AW-1:0] a0;
        for (int k = 0; k < 20 && !m_arvalid; k++) tick();
        if (!m_arvalid) chk("arvalid_timeout", 0, 1);
        a0 = m_araddr;
        for (int k = 0; k < wait_cyc; k++) tick();
        if (wait_cyc > 0) chk("ar_stable", {m_arvalid, m_araddr}, {1'b1, a0});
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
    endtask

    task automatic r_beats(input int n, input int gap, input int rid, input int last_at,
                           input logic [DW-1:0] base);
        for (int b = 0; b < n; b++) begin
            if (gap != 0) begin
                m_rvalid = 1'b0;
                tick();
            end
            m_rvalid = 1'b1;
            m_rdata  = base + DW'(b);
            m_rlast  = (b == last_at);
            m_rid    = IW'(rid);
            m_rresp  = 2'b00;
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    logic [N-1:0] seen;
    int           base_rv, base_rl, base_hs, base_g;
    int           exp_g [6];

    initial begin
        // Per-cycle comparison of every output against the model.
        fork
            forever begin
                @(negedge clk);
                begin : cyc
                    logic [N-1:0]  e_arready, e_rvalid;
                    logic [DW-1:0] e_rdata;
                    logic          e_rlast, e_arvalid, e_rready, e_err;
                    logic [IW-1:0] e_arid;
                    logic [AW-1:0] e_araddr;
                    logic [3:0]    e_arlen;
                    logic [2:0]    e_arsize;
                    logic [1:0]    e_arburst;
                    logic [OW-1:0] e_vec;
                    int            w;
                    e_arready = '0; e_rvalid = '0; e_rdata = '0; e_rlast = 1'b0;
                    e_arvalid = 1'b0; e_rready = 1'b0; e_arid = '0; e_araddr = '0;
                    e_arlen = '0; e_arsize = '0; e_arburst = '0;
                    e_err = rst ? 1'b0 : md_err;
                    if (!rst) begin
                        if (md_phase == 0) begin
                            w = pick(ch_arvalid, model_start());
                            if (w >= 0) e_arready[w] = 1'b1;
                        end else if (md_phase == 1) begin
                            e_arvalid = 1'b1; e_arid = IW'(md_owner); e_araddr = md_addr;
                            e_arlen = md_len; e_arsize = md_size; e_arburst = 2'b01;
                        end else begin
                            e_rready = 1'b1; e_rvalid[md_owner] = m_rvalid;
                            e_rdata = m_rdata; e_rlast = m_rlast;
                        end
                    end
                    e_vec = {e_arready, e_rvalid, e_rdata, e_rlast, e_arid, e_araddr, e_arlen,
                             e_arsize, e_arburst, e_arvalid, e_rready, e_err};
                    total++;
                    if (out_vec !== e_vec) begin
                        bad++;
                        $display("FAIL cycle t=%0t got=%h exp=%h", $time, out_vec, e_vec);
                    end
                end
            end
        join_none

        do_reset();
        chk("rst_arvalid", 64'(m_arvalid), 0);
        chk("rst_err", 64'(err_sticky), 0);
        chk("rst_outs_zero", 64'(out_vec == '0), 1);

        // Single request on channel 1, 4 beats.
        base_rv = rv_cnt; base_rl = rl_cnt;
        req(1, 32'h1FC0_0000, 4'd3, seen);
        chk("t1_grant", 64'(seen), 64'(3'b010));
        chk("t1_arid", 64'(m_arid), 1);
        chk("t1_arlen", 64'(m_arlen), 3);
        chk("t1_araddr", 64'(m_araddr), 64'h1FC0_0000);
        chk("t1_arburst", 64'(m_arburst), 1);
        ar_accept(0);
        r_beats(4, 0, 1, 3, 32'hA0);
        chk("t1_rvalid_cnt", 64'(rv_cnt - base_rv), 4);
        chk("t1_rlast_cnt", 64'(rl_cnt - base_rl), 1);
        chk("t1_err", 64'(err_sticky), 0);

        // All channels requesting continuously, 1-beat bursts.
        do_reset();
        for (int c = 0; c < N; c++) begin
            ch_araddr[c*AW +: AW] = 32'h1000 * (c + 1);
            ch_arlen[c*4 +: 4]    = 4'd0;
            ch_arsize[c*3 +: 3]   = 3'd2;
        end
        base_g = glog.size();
        ch_arvalid = '1;
        for (int t = 0; t < 6; t++) begin
            ar_accept(0);
            r_beats(1, 0, md_owner, 0, 32'h10 + DW'(t));
        end
        ch_arvalid = '0;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 0, 1, 2};
`endif
        chk("t2_grant_count", 64'(glog.size() - base_g >= 6), 1);
        for (int t = 0; t < 6; t++) begin
            if (base_g + t < glog.size()) chk("t2_grant_order", 64'(glog[base_g + t]),
                                              64'(exp_g[t]));
        end
        chk("t2_err", 64'(err_sticky), 0);

        // AR backpressure for 5 cycles.
        do_reset();
        base_hs = hs_cnt;
        req(1, 32'h2000_0040, 4'd1, seen);
        ar_accept(5);
        r_beats(2, 0, 1, 1, 32'hD0);
        chk("t3_handshakes", 64'(hs_cnt - base_hs), 1);
        chk("t3_err", 64'(err_sticky), 0);

        // Early last on beat 2 of a 4-beat burst.
        do_reset();
        req(0, 32'h3000_0000, 4'd3, seen);
        ar_accept(0);
        r_beats(2, 0, 0, 1, 32'hB0);
        chk("t4_early_err", 64'(err_sticky), 1);
        chk("t4_idle_arvalid", 64'(m_arvalid), 0);
        chk("t4_idle_rready", 64'(m_rready), 0);
        req(2, 32'h3000_0100, 4'd0, seen);
        chk("t4_next_grant", 64'(seen), 64'(3'b100));
        ar_accept(0);
        r_beats(1, 0, 2, 0, 32'hB8);
        // Wrong RID on an otherwise clean burst.
        do_reset();
        req(0, 32'h3000_0200, 4'd0, seen);
        ar_accept(0);
        r_beats(1, 0, 5, 0, 32'hBC);
        chk("t4_rid_err", 64'(err_sticky), 1);

        // Reset in the middle of the data phase.
        do_reset();
        req(2, 32'h4000_0000, 4'd3, seen);
        ar_accept(0);
        r_beats(2, 0, 2, 99, 32'hE0);
        m_rvalid = 1'b1;
        m_rid = IW'(2);
        ch_arvalid[1] = 1'b1;
        rst = 1'b1;
        #1;
        chk("t5_outs_zero", 64'(out_vec == '0), 1);
        tick();
        m_rvalid = 1'b0;
        tick();
        rst = 1'b0;
        req(1, 32'h4000_1000, 4'd0, seen);
        chk("t5_fresh_grant", 64'(seen), 64'(3'b010));
        chk("t5_fresh_arid", 64'(m_arid), 1);
        ar_accept(0);
        r_beats(1, 0, 1, 0, 32'hE8);
        chk("t5_err", 64'(err_sticky), 0);

        // R-channel gaps over an 8-beat burst.
        do_reset();
        req(0, 32'h5000_0000, 4'd7, seen);
        ar_accept(0);
        base_rv = rv_cnt; base_rl = rl_cnt;
        r_beats(8, 1, 0, 7, 32'hC0);
        tick();
        chk("t6_rvalid_cnt", 64'(rv_cnt - base_rv), 8);
        chk("t6_rlast_cnt", 64'(rl_cnt - base_rl), 1);
        chk("t6_err", 64'(err_sticky), 0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Parametrised read-channel arbiter that merges NUM_CH independent read requesters (instruction cache, data cache, uncached data path, and later additions) onto one AXI3 read address/data channel pair. It keeps exactly one read transaction outstanding, tags it with the requester index on ARID, and routes the returning beats back to the owner. It sits between the cache/uncache bus interfaces and the top-level AXI master ports, and replaces the fixed three-way read muxing inside the current AXI interaction block.

## Interface
- NUM_CH, 3, number of requesters (2..8); channel 0 is the lowest index
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, ARID/RID width; must satisfy 2^ID_W >= NUM_CH

- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- ch_arvalid  in  NUM_CH  per-channel request valid
- ch_araddr  in  NUM_CH*ADDR_W  per-channel address; channel i in bits [i*ADDR_W +: ADDR_W]
- ch_arlen  in  NUM_CH*4  per-channel burst length minus 1
- ch_arsize  in  NUM_CH*3  per-channel beat size
- ch_arready  out  NUM_CH  one-hot grant/accept pulse
- ch_rvalid  out  NUM_CH  one-hot beat valid to the owner
- ch_rdata  out  DATA_W  broadcast read data
- ch_rlast  out  1  broadcast last-beat flag
- m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid  out  ID_W/ADDR_W/4/3/2/1  AXI AR channel
- m_arready  in  1
- m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  in  ID_W/DATA_W/2/1/1  AXI R channel
- m_rready  out  1
- err_sticky  out  1  protocol-error flag; cleared only by reset

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: If any ch_arvalid is high, select one winner g combinationally and drive ch_arready[g]=1 in the same cycle. On the clock edge, register the winner's addr/len/size and g, load beat_cnt=arlen, and go to ADDR.
- Arbitration: round-robin. The search starts at rr_ptr and wraps modulo NUM_CH. After the last beat completes, rr_ptr becomes g+1, wrapping to 0 after NUM_CH-1.
- ADDR: m_arvalid=1 with registered fields. m_arid=g zero-extended, m_arburst=2'b01 (INCR). Fields stay stable until m_arready. On m_arvalid&m_arready, go to DATA.
- DATA: m_rready=1. ch_rvalid[g]=m_rvalid; ch_rdata=m_rdata and ch_rlast=m_rlast are passed through combinationally. Requesters must accept every beat.
- Each accepted beat decrements beat_cnt.
- When m_rlast is accepted, go to IDLE.
- err_sticky is set by any of the following:
  - m_rlast arrives while beat_cnt!=0
  - a beat arrives with beat_cnt==0 and m_rlast low
  - m_rid!=g
  - m_rresp!=2'b00
- Errors do not change data routing.
- Outside DATA, ch_rvalid=0 and m_rready=0, and m_rvalid is ignored.

## Timing
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, err_sticky=0, and all outputs 0 (m_arvalid, m_rready, ch_arready, ch_rvalid, ch_rdata, ch_rlast, m_ar* fields).
- Request-to-AR latency: ch_arready at cycle 0, m_arvalid from cycle 1.
- Minimum occupancy is 3 cycles for a 1-beat burst with zero-wait slave (IDLE, ADDR, DATA). The next grant is possible in the cycle after the last beat.
- m_arvalid never drops before m_arready.
- Requests arriving while not in IDLE are held off; ch_arready stays 0.
- When several channels request simultaneously, exactly one ch_arready bit is set, per the arbitration rule.
- A channel dropping ch_arvalid before grant is legal and is simply not selected.
- If rst is asserted mid-transaction, everything returns to reset values immediately and the outstanding AXI transaction is abandoned. The slave is reset in the same domain.

## Configuration
- AXI_RD_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest index wins. rr_ptr is not implemented, and the search always starts at channel 0.
- Undefined (default): round-robin, as described above.

## Test plan
- Single request: ch 1 requests addr 0x1FC0_0000, arlen 3. Expect ch_arready[1] at cycle 0, then m_arvalid with m_arid=1 and m_arlen=3. Return 4 beats 0xA0..0xA3. Expect ch_rvalid[1] on each beat, ch_rlast on the 4th, err_sticky=0.
- All 3 channels requesting continuously, 1-beat bursts: grants in order 0,1,2,0,1,2. With the macro defined, every grant goes to 0.
- AR backpressure: m_arready held low 5 cycles. m_arvalid and all AR fields stay stable; exactly one AR handshake occurs.
- Early m_rlast on beat 2 of an arlen=3 burst: err_sticky=1 and the FSM returns to IDLE. A wrong m_rid (5 for g=0) also sets err_sticky.
- Reset asserted during DATA after 2 of 4 beats: all outputs are 0 in the same cycle, FSM is in IDLE, and a fresh request afterward is granted normally.
- R-channel gaps: m_rvalid toggles every other cycle over an arlen=7 burst. Exactly 8 ch_rvalid pulses occur, with ch_rlast only on the last.
